// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
//
// Purpose:
//   Turns a single start pulse from the front-panel capture stage into a burst
//   of bytes for the UART TX core. Byte k of the burst carries data+k (mod 256).
//   An optional inter-byte gap (0, 0.5, 1 or 2 s) separates consecutive bytes.
//   Progress (bytes_sent) and completion (done) go to the display logic.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   CE             in   baud-rate clock enable; every register advances only when CE=1
//   start          in   one-CE-cycle start pulse, ignored while a burst is running
//   data[7:0]      in   value of the first byte in the burst
//   bytes_to_send  in   burst length (0 gives an immediate done with no bytes)
//   delay_sel[1:0] in   inter-byte gap: 00=none, 01=0.5 s, 10=1 s, 11=2 s
//   tx_busy        in   busy flag of the UART TX core
//   tx_start       out  one-CE-cycle byte request to the TX core
//   tx_data[7:0]   out  byte for the TX core, stable from tx_start until tx_busy falls
//   busy           out  burst in progress
//   done           out  one-CE-cycle pulse at burst completion
//   bytes_sent     out  bytes completed in the current or most recent burst
//
// Handshake with the TX core:
//   tx_start is high for exactly one CE-qualified cycle (the REQ state). The
//   sequencer then waits for tx_busy=1 (byte accepted), then for tx_busy=0
//   (byte finished). tx_data does not change between those events.
// -----------------------------------------------------------------------------
module uart_tx_sequencer #(
    parameter int HALF_SEC_TICKS = 28800,
    parameter int GAP_W          = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CE,
    input  logic        start,
    input  logic [7:0]  data,
    input  logic [14:0] bytes_to_send,
    input  logic [1:0]  delay_sel,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic [14:0] bytes_sent
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        REQ    = 3'd2,
        ACK    = 3'd3,
        XMIT   = 3'd4,
        GAP    = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    // Burst parameters captured at start; they never change mid-burst.
    logic [7:0]       data_lat;
    logic [14:0]      bytes_lat;
    logic [1:0]       delay_lat;
    logic [GAP_W-1:0] gap_cnt;

    // Datapath controls produced by the next-state logic, applied on CE.
    logic load_params;
    logic load_tx;
    logic inc_sent;
    logic load_gap;
    logic dec_gap;

    logic [14:0]      sent_inc;
    logic [GAP_W-1:0] gap_len;

    assign sent_inc = bytes_sent + 15'd1;

    // Gap length in CE ticks for the latched delay selection.
    always_comb begin
        gap_len = '0;
        case (delay_lat)
            2'b00:   gap_len = '0;
            2'b01:   gap_len = GAP_W'(HALF_SEC_TICKS);
            2'b10:   gap_len = GAP_W'(2 * HALF_SEC_TICKS);
            default: gap_len = GAP_W'(4 * HALF_SEC_TICKS);
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt   = state;
        load_params = 1'b0;
        load_tx     = 1'b0;
        inc_sent    = 1'b0;
        load_gap    = 1'b0;
        dec_gap     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_params = 1'b1;
                    // A zero-length burst still reports completion.
                    state_nxt = (bytes_to_send == 15'd0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                load_tx   = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                state_nxt = ACK;
            end
            ACK: begin
                if (tx_busy) begin
                    state_nxt = XMIT;
                end
            end
            XMIT: begin
                if (!tx_busy) begin
                    inc_sent = 1'b1;
                    if (sent_inc == bytes_lat) begin
                        state_nxt = FINISH;
                    end else if (gap_len == '0) begin
                        state_nxt = LOAD;
                    end else begin
                        load_gap  = 1'b1;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                // The XMIT cycle that saw tx_busy fall is the first gap tick,
                // so LOAD arrives exactly gap_len ticks after that fall.
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = LOAD;
                end else begin
                    dec_gap = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latched parameters, byte counter, gap counter and outgoing byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_lat   <= 8'd0;
            bytes_lat  <= 15'd0;
            delay_lat  <= 2'd0;
            gap_cnt    <= '0;
            bytes_sent <= 15'd0;
            tx_data    <= 8'd0;
        end else if (CE) begin
            if (load_params) begin
                data_lat   <= data;
                bytes_lat  <= bytes_to_send;
                delay_lat  <= delay_sel;
                bytes_sent <= 15'd0;
            end
            if (load_tx) begin
                // 8-bit wrap: byte 256 of a long burst repeats the first value.
                tx_data <= data_lat + bytes_sent[7:0];
            end
            if (inc_sent) begin
                bytes_sent <= sent_inc;
            end
            if (load_gap) begin
                gap_cnt <= gap_len - GAP_W'(1);
            end else if (dec_gap) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Moore outputs decoded from state; reset forces them low at once.
    assign tx_start = (state == REQ);
    assign done     = (state == FINISH);
    assign busy     = (state == LOAD) || (state == REQ) || (state == ACK) ||
                      (state == XMIT) || (state == GAP);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sequencer
//
// Bench for uart_tx_sequencer with HALF_SEC_TICKS=8. A TX core model goes busy
// for core_ticks CE ticks after each accepted tx_start. Drivers change inputs
// 2 ns after the rising clock edge; the monitor samples on the falling edge,
// where one sample with CE=1 is one CE cycle (index ce_idx).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_sequencer;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        CE;
  logic        start;
  logic [7:0]  data;
  logic [14:0] bytes_to_send;
  logic [1:0]  delay_sel;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [14:0] bytes_sent;

  logic [7:0]  exp_q[$];
  logic [14:0] exp_done_q[$];
  int req_log[$];
  int fall_log[$];
  int done_log[$];
  int start_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ce_idx = 0;
  int ce_hold_cnt = 0;
  int core_ticks = 10;
  logic prev_busy = 1'b0;

  uart_tx_sequencer #(.HALF_SEC_TICKS(HALF), .GAP_W(18)) dut (
    .clk(clk),
    .reset(reset),
    .CE(CE),
    .start(start),
    .data(data),
    .bytes_to_send(bytes_to_send),
    .delay_sel(delay_sel),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy),
    .done(done),
    .bytes_sent(bytes_sent)
  );

  // ---------------- clock / CE / reset-level infrastructure ----------------
  always #5 clk = ~clk;

  // CE on every other clock; ce_hold_cnt forces it low for that many clocks.
  initial begin
    CE = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ce_hold_cnt > 0) begin
        CE = 1'b0;
        ce_hold_cnt--;
      end else begin
        CE = ~CE;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- TX core model ----------------
  initial begin
    logic s;
    logic c;
    int cnt;
    tx_busy = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      s = tx_start;
      c = CE;
      @(posedge clk);
      #2;
      if (c) begin
        if (tx_busy) begin
          cnt--;
          if (cnt == 0) tx_busy = 1'b0;
        end else if (s) begin
          tx_busy = 1'b1;
          cnt = core_ticks;
        end
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [7:0]  eb;
    logic [14:0] ed;
    forever begin
      @(negedge clk);
      if (CE) begin
        ce_idx++;
        if (!reset) begin
          if (start) start_log.push_back(ce_idx);
          if (prev_busy && !tx_busy) fall_log.push_back(ce_idx);
          if (tx_start) begin
            req_log.push_back(ce_idx);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_tx_start: tx_data=%0h, no byte expected", tx_data);
            end else begin
              eb = exp_q.pop_front();
              check("tx_data", tx_data, eb);
            end
          end
          if (done) begin
            done_log.push_back(ce_idx);
            if (exp_done_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_done: bytes_sent=%0d, no done expected", bytes_sent);
            end else begin
              ed = exp_done_q.pop_front();
              check("done_bytes_sent", bytes_sent, ed);
              check("done_busy", busy, 0);
            end
          end
        end
        prev_busy = tx_busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [7:0] d, input logic [14:0] n, input logic [1:0] ds);
    do begin
      @(posedge clk);
      #2;
    end while (!CE);
    data = d;
    bytes_to_send = n;
    delay_sel = ds;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    // Scramble the inputs: the latched copies must be used from here on.
    data = ~d;
    bytes_to_send = 15'h2a5a;
    delay_sel = ~ds;
  endtask

  task automatic push_burst(input logic [7:0] d, input int n);
    logic [7:0] b;
    b = d;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(b);
      b = b + 8'd1;
    end
    exp_done_q.push_back(15'(n));
  endtask

  task automatic clear_logs();
    req_log.delete();
    fall_log.delete();
    done_log.delete();
    start_log.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((tx_busy || busy) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int max_clk);
    int k = 0;
    while (done_log.size() == 0 && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    check({name, "_done_count"}, done_log.size(), 1);
    check({name, "_exp_q_empty"}, exp_q.size(), 0);
    check({name, "_exp_done_empty"}, exp_done_q.size(), 0);
  endtask

  task automatic wait_req(input string name, input int n, input int max_clk);
    int k = 0;
    while (req_log.size() < n && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    check({name, "_req_reached"}, (req_log.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic pulse_reset_checked(input string name);
    reset = 1'b1;
    #1;
    check({name, "_tx_start"}, tx_start, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_bytes_sent"}, bytes_sent, 0);
    exp_q.delete();
    exp_done_q.delete();
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    data = 8'd0;
    bytes_to_send = 15'd0;
    delay_sel = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bytes_sent", bytes_sent, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, no gap
    clear_logs();
    push_burst(8'h41, 1);
    pulse_start(8'h41, 15'd1, 2'b00);
    wait_done("single", 400);
    check("single_req_count", req_log.size(), 1);
    check("single_latency", req_log[0] - start_log[0], 2);
    check("single_done_after_fall", done_log[0] - fall_log[0], 1);
    check("single_bytes_sent", bytes_sent, 1);
    check("single_busy_after", busy, 0);
    wait_idle();

    // Burst of 32 with 8-bit wrap of tx_data
    clear_logs();
    push_burst(8'hF0, 32);
    pulse_start(8'hF0, 15'd32, 2'b00);
    wait_done("burst32", 2500);
    check("burst32_req_count", req_log.size(), 32);
    check("burst32_bytes_sent", bytes_sent, 32);
    check("burst32_req_after_fall", req_log[1] - fall_log[0], 2);
    wait_idle();

    // Gap timing: 4*HALF = 32 ticks from tx_busy fall to LOAD, REQ one later
    clear_logs();
    push_burst(8'h80, 3);
    pulse_start(8'h80, 15'd3, 2'b11);
    wait_done("gap", 1000);
    check("gap_req_count", req_log.size(), 3);
    check("gap1_fall_to_req", req_log[1] - fall_log[0], 4 * HALF + 1);
    check("gap2_fall_to_req", req_log[2] - fall_log[1], 4 * HALF + 1);
    check("gap_last_done", done_log[0] - fall_log[2], 1);
    wait_idle();

    // Gap timing with 0.5 s selection
    clear_logs();
    push_burst(8'h07, 2);
    pulse_start(8'h07, 15'd2, 2'b01);
    wait_done("gap_half", 600);
    check("gap_half_fall_to_req", req_log[1] - fall_log[0], HALF + 1);
    wait_idle();

    // Start while busy: second request is ignored
    clear_logs();
    push_burst(8'h10, 4);
    pulse_start(8'h10, 15'd4, 2'b00);
    wait_req("sbusy", 1, 400);
    pulse_start(8'hAA, 15'd2, 2'b11);
    wait_done("sbusy", 800);
    check("sbusy_req_count", req_log.size(), 4);
    check("sbusy_bytes_sent", bytes_sent, 4);
    wait_idle();

    // Reset during GAP
    clear_logs();
    push_burst(8'h20, 3);
    pulse_start(8'h20, 15'd3, 2'b01);
    k = 0;
    while (fall_log.size() == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("rgap_fall_seen", fall_log.size(), 1);
    k = 0;
    while (k < 2) begin
      @(negedge clk);
      if (CE) k++;
    end
    @(posedge clk);
    #2;
    check("rgap_busy_before", busy, 1);
    check("rgap_sent_before", bytes_sent, 1);
    pulse_reset_checked("rgap");
    clear_logs();
    repeat (40) @(negedge clk);
    check("rgap_stays_idle_req", req_log.size(), 0);
    check("rgap_stays_idle_busy", busy, 0);
    check("rgap_stays_idle_done", done_log.size(), 0);
    wait_idle();

    // Reset during ACK, then a normal single-byte burst
    clear_logs();
    push_burst(8'h30, 5);
    pulse_start(8'h30, 15'd5, 2'b00);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(tx_start && CE) && k < 400);
    @(posedge clk);
    #2;
    check("rack_busy_before", busy, 1);
    check("rack_data_before", tx_data, 8'h30);
    pulse_reset_checked("rack");
    wait_idle();
    clear_logs();
    repeat (20) @(negedge clk);
    check("rack_stays_idle_req", req_log.size(), 0);
    push_burst(8'h7E, 1);
    pulse_start(8'h7E, 15'd1, 2'b00);
    wait_done("after_rst", 400);
    check("after_rst_req_count", req_log.size(), 1);
    check("after_rst_bytes_sent", bytes_sent, 1);
    wait_idle();

    // CE held low while in REQ: tx_start holds and is counted once
    clear_logs();
    push_burst(8'h5C, 1);
    pulse_start(8'h5C, 15'd1, 2'b00);
    k = 0;
    while (!(tx_start === 1'b1 && CE === 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    ce_hold_cnt = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ce_hold_tx_start", tx_start, 1);
    end
    wait_done("ce_hold", 400);
    check("ce_hold_req_count", req_log.size(), 1);
    wait_idle();

    // Zero-length burst
    clear_logs();
    exp_done_q.push_back(15'd0);
    pulse_start(8'h55, 15'd0, 2'b00);
    wait_done("zero", 200);
    check("zero_req_count", req_log.size(), 0);
    check("zero_done_latency", done_log[0] - start_log[0], 1);
    check("zero_bytes_sent", bytes_sent, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
